// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl
//   Direction predictor and resolution tracker for the 5-stage MIPS pipeline.
//   A PC-indexed pattern history table (PHT) of 2-bit saturating counters is
//   read combinationally in ID. The prediction travels with the branch into
//   EX, where it is compared against the resolved direction. Each EX branch
//   commits exactly once, training the PHT and updating the statistics.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stallD, stallE    ID / EX stage held this cycle
//   flushE            EX stage bubbled by the hazard unit
//   branchD, pcD      ID instruction is a conditional branch, and its PC
//   actual_takeE      resolved direction of the EX branch
//   pred_takeD        predicted direction for the ID branch
//   branch_validE     EX stage holds a predicted branch
//   pred_takeE        prediction carried with the EX branch
//   mispredictE       EX branch prediction was wrong (not gated by stallE)
//   branch_cnt        resolved branches since reset (saturating)
//   mispred_cnt       mispredicted branches since reset (saturating)
module branch_pred_ctrl #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        branchD,
    input  logic [31:0] pcD,
    input  logic        actual_takeE,
    output logic        pred_takeD,
    output logic        branch_validE,
    output logic        pred_takeE,
    output logic        mispredictE,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]       pht [ENTRIES];
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic             valid_e;
    logic             pred_e;
    logic             commit;

    // Only the word-aligned index bits of the PC address the table.
    logic unused_pc;
    assign unused_pc = ^{pcD[31:IDX_W+2], pcD[1:0]};

    assign idx_d       = pcD[IDX_W+1:2];
    assign pred_takeD  = branchD & pht[idx_d][1];

    assign branch_validE = valid_e;
    assign pred_takeE    = pred_e & valid_e;
    assign mispredictE   = valid_e & (pred_e ^ actual_takeE);

    // A flushed EX branch still commits: the flush only affects what enters EX.
    assign commit = valid_e & ~stallE;

    // D->E pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e <= 1'b0;
            pred_e  <= 1'b0;
            idx_e   <= '0;
        end else if (flushE) begin
            valid_e <= 1'b0;
        end else if (!stallE) begin
            if (stallD) begin
                valid_e <= 1'b0;
            end else begin
                valid_e <= branchD;
                pred_e  <= pred_takeD;
                // pcD is meaningless without a branch; keep it out of state.
                if (branchD) begin
                    idx_e <= idx_d;
                end
            end
        end
    end

    // PHT training; no bypass, so ID sees the update one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= INIT_CNT;
            end
        end else if (commit) begin
            if (actual_takeE) begin
                if (pht[idx_e] != 2'b11) begin
                    pht[idx_e] <= pht[idx_e] + 2'b01;
                end
            end else begin
                if (pht[idx_e] != 2'b00) begin
                    pht[idx_e] <= pht[idx_e] - 2'b01;
                end
            end
        end
    end

    // Statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (commit) begin
            if (branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredictE && (mispred_cnt != CNT_MAX)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule
